// File: rtl/ed25519_pkg.sv
// Shared Ed25519 field constants, base point and point_encode state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ed25519_pkg;

    localparam int B = 256;

    // q = 2^255 - 19
    localparam logic [B-1:0] Q =
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    // q - 2; bit 254 is the most significant set bit
    localparam logic [B-1:0] EXP =
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffeb;

    localparam logic [B-1:0] ONE = {{(B-1){1'b0}}, 1'b1};

    // Ed25519 base point, affine coordinates
    localparam logic [B-1:0] BX =
        256'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
    localparam logic [B-1:0] BY =
        256'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ZCHK,
        ST_SQR,
        ST_MUL,
        ST_FX,
        ST_FY,
        ST_OUT
    } pe_state_e;

endpackage

// File: rtl/mod_mul_25519.sv
// Modular multiplier a*b mod 2^255-19, 64-bit digit-serial over b with a 2^255=19 fold per digit.
// Latency: done pulses 5 cycles after the start cycle; res fully reduced (< q) and held until next done.
// Backpressure: start is ignored while an operation is running; a and b are captured on start.
module mod_mul_25519
    import ed25519_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [B-1:0] a,
    input  logic [B-1:0] b,
    output logic         done,
    output logic [B-1:0] res
);

    logic         run_q, run_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [B-1:0] a_q, a_d;
    logic [B-1:0] b_q, b_d;
    logic [B-1:0] acc_q, acc_d;
    logic [B-1:0] res_q, res_d;
    logic         done_q, done_d;

    logic [63:0]  digit;
    logic [319:0] prod;
    logic [320:0] sum;
    logic [B-1:0] fold;
    logic [B-1:0] fin;
    logic [B-1:0] red;

    // Horner step: acc*2^64 + a*digit stays below 2^321, one fold brings it back under 2^256
    always_comb begin
        digit = b_q[{cnt_q, 6'd0} +: 64];
        prod  = {64'd0, a_q} * {256'd0, digit};
        sum   = {1'b0, acc_q, 64'd0} + {1'b0, prod};
        fold  = {1'b0, sum[254:0]} + ({190'd0, sum[320:255]} * 256'd19);
        fin   = {1'b0, fold[254:0]} + (fold[255] ? 256'd19 : 256'd0);
        red   = (fin >= Q) ? (fin - Q) : fin;
    end

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        res_d  = res_q;
        done_d = 1'b0;
        if (!run_q) begin
            if (start) begin
                a_d   = a;
                b_d   = b;
                acc_d = '0;
                cnt_d = 2'd3;
                run_d = 1'b1;
            end
        end else begin
            acc_d = fold;
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd0) begin
                run_d  = 1'b0;
                res_d  = red;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            cnt_q  <= 2'd0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            res_q  <= res_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign res  = res_q;

endmodule

// File: rtl/point_encode.sv
// Compresses extended Ed25519 point (X:Y:Z:T) to {x[0], y[254:0]} via Fermat inversion of Z.
// Latency: 509*(L_mul+1)+2 cycles start-to-done; Z = 0 mod q reports err after one op (L_mul+2).
// Backpressure: start ignored while busy and in the done cycle; enc/err held until next done.
module point_encode
    import ed25519_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [B-1:0] x_in,
    input  logic [B-1:0] y_in,
    input  logic [B-1:0] z_in,
    input  logic [B-1:0] t_in,
    output logic         busy,
    output logic         done,
    output logic [B-1:0] enc,
    output logic         err
);

    pe_state_e    state_q, state_d;
    logic [7:0]   i_q, i_d;
    logic [B-1:0] x_q, x_d;
    logic [B-1:0] y_q, y_d;
    logic [B-1:0] zr_q, zr_d;
    logic [B-1:0] acc_q, acc_d;
    logic [B-1:0] mul_a_q, mul_a_d;
    logic [B-1:0] mul_b_q, mul_b_d;
    logic         mul_start_q, mul_start_d;
    logic         xr0_q, xr0_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [B-1:0] enc_q, enc_d;

    logic         mul_done;
    logic [B-1:0] mul_res;
    logic         step_next;

    // T only exists so this block's inputs line up with point_add's outputs
    logic t_unused;
    assign t_unused = ^t_in;

    mod_mul_25519 u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start_q),
        .a     (mul_a_q),
        .b     (mul_b_q),
        .done  (mul_done),
        .res   (mul_res)
    );

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        x_d         = x_q;
        y_d         = y_q;
        zr_d        = zr_q;
        acc_d       = acc_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = 1'b0;
        xr0_d       = xr0_q;
        done_d      = 1'b0;
        err_d       = err_q;
        enc_d       = enc_q;
        step_next   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    x_d         = x_in;
                    y_d         = y_in;
                    mul_a_d     = z_in;
                    mul_b_d     = ONE;
                    mul_start_d = 1'b1;
                    i_d         = 8'd253;
                    state_d     = ST_ZCHK;
                end
            end
            // Z*1 is the only way to get Z reduced mod q out of the multiplier
            ST_ZCHK: begin
                if (mul_done) begin
                    if (mul_res == '0) begin
                        enc_d   = '0;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        zr_d        = mul_res;
                        acc_d       = mul_res;
                        mul_a_d     = mul_res;
                        mul_b_d     = mul_res;
                        mul_start_d = 1'b1;
                        state_d     = ST_SQR;
                    end
                end
            end
            ST_SQR: begin
                if (mul_done) begin
                    acc_d = mul_res;
                    if (EXP[i_q]) begin
                        mul_a_d     = mul_res;
                        mul_b_d     = zr_q;
                        mul_start_d = 1'b1;
                        state_d     = ST_MUL;
                    end else begin
                        step_next = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    acc_d     = mul_res;
                    step_next = 1'b1;
                end
            end
            ST_FX: begin
                if (mul_done) begin
                    xr0_d       = mul_res[0];
                    mul_a_d     = y_q;
                    mul_b_d     = acc_q;
                    mul_start_d = 1'b1;
                    state_d     = ST_FY;
                end
            end
            ST_FY: begin
                if (mul_done) begin
                    state_d = ST_OUT;
                end
            end
            // Multiplier result still holds y here; no new op has been issued
            ST_OUT: begin
                enc_d   = {xr0_q, mul_res[254:0]};
                err_d   = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of one exponent bit: either the next squaring or, after bit 0, x = X * Z^-1
        if (step_next) begin
            mul_start_d = 1'b1;
            if (i_q == 8'd0) begin
                mul_a_d = x_q;
                mul_b_d = mul_res;
                state_d = ST_FX;
            end else begin
                i_d     = i_q - 8'd1;
                mul_a_d = mul_res;
                mul_b_d = mul_res;
                state_d = ST_SQR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            i_q         <= 8'd0;
            x_q         <= '0;
            y_q         <= '0;
            zr_q        <= '0;
            acc_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            xr0_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            enc_q       <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            x_q         <= x_d;
            y_q         <= y_d;
            zr_q        <= zr_d;
            acc_q       <= acc_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
            xr0_q       <= xr0_d;
            done_q      <= done_d;
            err_q       <= err_d;
            enc_q       <= enc_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign enc  = enc_q;
    assign err  = err_q;

endmodule

// File: doc/point_encode.md
Name: point_encode

Overview:
- Converts an extended-coordinate Ed25519 point (X:Y:Z:T), as produced by the point adder / scalar-multiply datapath, into the 256-bit compressed encoding used on the wire.
- Encoding is y | (x[0] << 255), with x = X/Z mod q and y = Y/Z mod q.
- Z^-1 is computed by Fermat inversion, Z^(q-2) mod q, using sequential square-and-multiply on one shared modular multiplier.
- Sits at the output end of the signing/keygen pipeline, after point_add.

Parameters:
- B, 256, operand/encoding width in bits.
- Q, 2^255-19, field prime (from shared package).
- EXP, 2^255-21 (q-2), inversion exponent (from shared package; bit 254 is the MSB).

Ports:
- clk    in   1    system clock, rising edge.
- rst_n  in   1    asynchronous active-low reset.
- start  in   1    1-cycle pulse; begin encoding of inputs. Ignored unless idle.
- x_in   in   256  extended X (any value < 2^256; reduced internally by multiplier).
- y_in   in   256  extended Y.
- z_in   in   256  extended Z.
- t_in   in   256  extended T; unused, present for interface symmetry with point_add.
- busy   out  1    high from the cycle after an accepted start until done.
- done   out  1    1-cycle pulse; enc/err valid.
- enc    out  256  compressed point {x[0], y[254:0]}; held until next done.
- err    out  1    Z ≡ 0 mod q (point at infinity / invalid); held until next done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, enc=0, err=0; multiplier start deasserted; latched operands cleared.
- IDLE:
  - On start: latch x_in, y_in, z_in; bit index i=253; go to ZCHK.
  - The multiplier cannot be asked for Z mod q directly, so ZCHK issues Z*1 through it.
- ZCHK: issue mod_mul(Z,1), wait for its done.
  - Result 0: enc=0, err=1, pulse done, return to IDLE.
  - Otherwise: acc=Zr (the reduced Z), go to SQR.
- SQR: issue mod_mul(acc,acc), acc=result.
  - If EXP[i]=1, go to MUL; else go to NEXT.
- MUL: issue mod_mul(acc,Zr), acc=result, go to NEXT.
- NEXT:
  - If i==0: acc holds Z^-1, go to FX.
  - Else i=i-1, go to SQR.
- FX: xr = mod_mul(X, acc).
- FY: yr = mod_mul(Y, acc).
- OUT: enc={xr[0], yr[254:0]}, err=0, pulse done (exactly one cycle), go to IDLE.
- Operation count per successful encode: 1 check + 254 squarings + 252 multiplies + 2 final = 509 mod_mul ops. The bench checks this via a counter.
- Latency: 509*(L_mul+1) + 2 cycles, with L_mul the mod_mul start-to-done latency. No other stall sources.
- Exactly one mod_mul op is outstanding at a time. mod_mul start is a 1-cycle pulse issued the cycle after operands are registered. Operands must not change while the op is outstanding.
- start while busy: ignored; no restart, no error.
- start in the same cycle as done: ignored; the caller must wait a cycle.
- rst_n low mid-operation: immediate abort to reset values. Any in-flight mod_mul result is discarded; mod_mul is also reset.
- All field results < q. enc bit 255 is always x[0] of the fully reduced x.

Decomposition:
- Package ed25519_pkg: B, Q, EXP (q-2), base-point constants BX, BY for benches, state enum for point_encode.
- Sub-module mod_mul_25519 (start/done handshake, 256x256 product reduced mod q via the 2^255 ≡ 19 fold). Reusable by point_add later.
- FSM and exponent bit counter live in point_encode.

Test Plan:
- Z=1, X=5, Y=7 -> done, err=0, enc = 2^255 + 7.
- Z=2, X=2, Y=4 -> x=1, y=2 -> enc = 2^255 + 2. Check op count = 509.
- Base point, X=BX, Y=BY, Z=1 -> enc = 256'h6666666666666666666666666666666666666666666666666666666666666658 (x even).
- Base point scaled, X=3BX mod q, Y=3BY mod q, Z=3 -> same enc as the base-point case.
- Z=0 and separately Z=q -> done after the ZCHK op, err=1, enc=0. A following valid encode clears err.
- Assert rst_n=0 at op ~200, then restart with the Z=2 case -> outputs reset immediately; the later encode matches the expected value. A start pulse while busy has no effect.
